// File: rtl/dsa_job_scheduler_if.sv
// rtl/dsa_job_scheduler_if.sv - job, core and status signals of the job scheduler
interface dsa_job_scheduler_if #(
    parameter int DEPTH = 4,
    parameter int CW    = 32
);
    localparam int PW = $clog2(DEPTH + 1);

    logic          job_valid;
    logic          job_ready;
    logic [15:0]   job_in_w;
    logic [15:0]   job_in_h;
    logic [15:0]   job_scale_q88;
    logic          job_reject;
    logic          abort;
    logic          core_start;
    logic          core_busy;
    logic          core_done;
    logic [15:0]   core_in_w;
    logic [15:0]   core_in_h;
    logic [15:0]   core_scale_q88;
    logic          stat_valid;
    logic [CW-1:0] stat_cycles;
    logic          stat_timeout;
    logic [PW-1:0] jobs_pending;
    logic          idle;

    modport master (
        output job_valid, job_in_w, job_in_h, job_scale_q88, abort, core_busy, core_done,
        input  job_ready, job_reject, core_start, core_in_w, core_in_h, core_scale_q88,
               stat_valid, stat_cycles, stat_timeout, jobs_pending, idle
    );

    modport slave (
        input  job_valid, job_in_w, job_in_h, job_scale_q88, abort, core_busy, core_done,
        output job_ready, job_reject, core_start, core_in_w, core_in_h, core_scale_q88,
               stat_valid, stat_cycles, stat_timeout, jobs_pending, idle
    );
endinterface

// File: rtl/dsa_job_scheduler.sv
// rtl/dsa_job_scheduler.sv - job FIFO, core sequencer, cycle counter and watchdog for the scaler
module dsa_job_scheduler #(
    parameter int DEPTH   = 4,
    parameter int CW      = 32,
    parameter int TIMEOUT = 16777216
) (
    input  logic               clk_50,
    input  logic               rst_n,
    dsa_job_scheduler_if.slave bus
);
    localparam int            AW     = $clog2(DEPTH);
    localparam int            PW     = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);
    localparam logic [PW-1:0] FULL   = PW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [47:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [47:0]   cfg_q, cfg_d;
    logic [CW-1:0] stat_cycles_q, stat_cycles_d;
    logic          stat_valid_q, stat_valid_d;
    logic          stat_to_q, stat_to_d;
    logic          reject_q, reject_d;
    logic          job_ready;
    logic          push_req;
    logic          job_ok;
    logic          push;
    logic          pop;

    // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
    assign job_ready = (count_q < FULL);
    assign push_req  = bus.job_valid && job_ready && !bus.abort;
    assign job_ok    = (bus.job_in_w != 16'd0) && (bus.job_in_h != 16'd0) &&
                       (bus.job_scale_q88 != 16'd0);
    assign push      = push_req && job_ok;
    assign reject_d  = push_req && !job_ok;
    assign cnt_inc   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!push && pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.job_in_w, bus.job_in_h, bus.job_scale_q88};
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cfg_d         = cfg_q;
        stat_cycles_d = stat_cycles_q;
        stat_valid_d  = 1'b0;
        stat_to_d     = stat_to_q;
        pop           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0 && !bus.core_busy) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // An abort on the IDLE->LOAD edge can leave nothing to load.
                if (count_q != '0) begin
                    pop     = 1'b1;
                    cfg_d   = mem_q[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                cnt_d   = cnt_inc;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                if (bus.core_done) begin
                    stat_cycles_d = cnt_inc;
                    stat_valid_d  = 1'b1;
                    state_d       = S_IDLE;
                end else if (cnt_inc == TO_LIM) begin
                    stat_cycles_d = TO_LIM;
                    stat_to_d     = 1'b1;
                    stat_valid_d  = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cnt_q         <= '0;
            cfg_q         <= '0;
            stat_cycles_q <= '0;
            stat_valid_q  <= 1'b0;
            stat_to_q     <= 1'b0;
            reject_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cnt_q         <= cnt_d;
            cfg_q         <= cfg_d;
            stat_cycles_q <= stat_cycles_d;
            stat_valid_q  <= stat_valid_d;
            stat_to_q     <= stat_to_d;
            reject_q      <= reject_d;
        end
    end

    assign bus.job_ready      = job_ready;
    assign bus.job_reject     = reject_q;
    assign bus.core_start     = (state_q == S_START);
    assign bus.core_in_w      = cfg_q[47:32];
    assign bus.core_in_h      = cfg_q[31:16];
    assign bus.core_scale_q88 = cfg_q[15:0];
    assign bus.stat_valid     = stat_valid_q;
    assign bus.stat_cycles    = stat_cycles_q;
    assign bus.stat_timeout   = stat_to_q;
    assign bus.jobs_pending   = count_q;
    assign bus.idle           = (state_q == S_IDLE) && (count_q == '0);
endmodule

// File: tb/tb_dsa_job_scheduler.sv
// tb/tb_dsa_job_scheduler.sv - scoreboard bench for dsa_job_scheduler with a reactive core model
module tb_dsa_job_scheduler;
    localparam int DEPTH   = 4;
    localparam int CW      = 32;
    localparam int TIMEOUT = 150;

    typedef struct {
        logic [15:0] w;
        logic [15:0] h;
        logic [15:0] s;
    } cfg_t;

    typedef struct {
        int cyc;
        bit to;
    } stat_t;

    logic clk_50 = 1'b0;
    logic rst_n  = 1'b0;
    logic model_busy = 1'b0;
    logic hold_busy  = 1'b0;
    logic release_hang = 1'b0;
    logic done_r = 1'b0;

    cfg_t  cfg_q[$];
    stat_t stat_q[$];
    int    lat_q[$];
    cfg_t  mon_cfg;
    stat_t mon_stat;
    bit    sticky = 1'b0;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;
    int n_stats = 0;
    int n_rej_seen = 0;
    int exp_rej = 0;
    int last_push_cyc = 0;
    int last_start_cyc = 0;
    int st0, s0;

    dsa_job_scheduler_if #(.DEPTH(DEPTH), .CW(CW)) bus ();

    dsa_job_scheduler #(.DEPTH(DEPTH), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    assign bus.core_busy = model_busy | hold_busy;
    assign bus.core_done = done_r;

    always #10 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_job(input logic [15:0] w, input logic [15:0] h, input logic [15:0] s);
        int waited = 0;
        @(negedge clk_50);
        while (!bus.job_ready && waited < 3000) begin
            @(negedge clk_50);
            waited++;
        end
        if (!bus.job_ready) begin
            chk("push_ready_wait", 0, 1);
            return;
        end
        bus.job_valid     = 1'b1;
        bus.job_in_w      = w;
        bus.job_in_h      = h;
        bus.job_scale_q88 = s;
        @(posedge clk_50);
        #1;
        last_push_cyc = cyc;
        bus.job_valid = 1'b0;
        if (w != 0 && h != 0 && s != 0) cfg_q.push_back('{w: w, h: h, s: s});
        else exp_rej++;
    endtask

    task automatic do_abort();
        @(negedge clk_50);
        bus.abort         = 1'b1;
        bus.job_valid     = 1'b1;
        bus.job_in_w      = 16'd7;
        bus.job_in_h      = 16'd7;
        bus.job_scale_q88 = 16'h0080;
        @(posedge clk_50);
        #1;
        bus.abort     = 1'b0;
        bus.job_valid = 1'b0;
        cfg_q.delete();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk_50);
        while (!(bus.idle && !bus.core_busy && stat_q.size() == 0) && n < 6000) begin
            @(negedge clk_50);
            n++;
        end
        chk(name, {63'd0, bus.idle && !bus.core_busy && stat_q.size() == 0}, 64'd1);
    endtask

    task automatic wait_starts(input string name, input int target);
        int n = 0;
        while (n_starts < target && n < 500) begin
            @(negedge clk_50);
            n++;
        end
        chk(name, n_starts, target);
    endtask

    task automatic wait_stats(input string name, input int target);
        int n = 0;
        while (n_stats < target && n < 1000) begin
            @(negedge clk_50);
            n++;
        end
        chk(name, n_stats, target);
    endtask

    // Core model: reacts to core_start with a chosen latency and registers the expected status.
    initial begin
        int lat;
        int k;
        forever begin
            @(negedge clk_50);
            if (rst_n && bus.core_start) begin
                lat = (lat_q.size() != 0) ? lat_q.pop_front() : int'($urandom_range(2, 60));
                if (lat == 0) begin
                    sticky = 1'b1;
                    stat_q.push_back('{cyc: TIMEOUT, to: 1'b1});
                end else begin
                    stat_q.push_back('{cyc: lat, to: sticky});
                end
                model_busy = 1'b1;
                if (lat == 0) begin
                    while (!release_hang && rst_n) @(negedge clk_50);
                end else begin
                    k = 1;
                    while (k < lat && rst_n) begin
                        @(negedge clk_50);
                        k++;
                    end
                    if (rst_n) begin
                        done_r = 1'b1;
                        @(negedge clk_50);
                        done_r = 1'b0;
                    end
                end
                model_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a start or a status.
    initial begin
        forever begin
            @(negedge clk_50);
            if (rst_n) begin
                if (bus.core_start) begin
                    n_starts++;
                    last_start_cyc = cyc;
                    if (cfg_q.size() == 0) begin
                        chk("unexpected_core_start", 1, 0);
                    end else begin
                        mon_cfg = cfg_q.pop_front();
                        chk("core_cfg", {bus.core_in_w, bus.core_in_h, bus.core_scale_q88},
                            {mon_cfg.w, mon_cfg.h, mon_cfg.s});
                    end
                end
                if (bus.stat_valid) begin
                    n_stats++;
                    if (stat_q.size() == 0) begin
                        chk("unexpected_stat_valid", 1, 0);
                    end else begin
                        mon_stat = stat_q.pop_front();
                        chk("stat_cycles", bus.stat_cycles, mon_stat.cyc);
                        chk("stat_timeout", bus.stat_timeout, mon_stat.to);
                    end
                end
                if (bus.job_reject) n_rej_seen++;
            end
        end
    end

    initial begin
        bus.job_valid     = 1'b0;
        bus.job_in_w      = 16'd0;
        bus.job_in_h      = 16'd0;
        bus.job_scale_q88 = 16'd0;
        bus.abort         = 1'b0;
        repeat (3) @(negedge clk_50);
        chk("rst_idle", bus.idle, 1);
        chk("rst_ready", bus.job_ready, 1);
        chk("rst_pending", bus.jobs_pending, 0);
        chk("rst_outputs", {bus.core_start, bus.stat_valid, bus.stat_timeout, bus.job_reject},
            4'b0000);
        chk("rst_core_cfg", {bus.core_in_w, bus.core_in_h, bus.core_scale_q88}, 48'd0);
        chk("rst_stat_cycles", bus.stat_cycles, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50);

        // Single job with a 100-cycle core.
        lat_q.push_back(100);
        push_job(16'd64, 16'd64, 16'h0100);
        wait_starts("single_start", 1);
        chk("single_start_latency", last_start_cyc - last_push_cyc, 2);
        wait_idle("single_idle");
        chk("single_one_start", n_starts, 1);
        chk("single_one_stat", n_stats, 1);
        chk("single_idle_after", bus.idle, 1);

        // Invalid jobs, one zero field each.
        st0 = n_starts;
        push_job(16'd0, 16'd64, 16'h0100);
        push_job(16'd64, 16'd0, 16'h0100);
        push_job(16'd64, 16'd64, 16'h0000);
        repeat (4) @(negedge clk_50);
        chk("invalid_reject_count", n_rej_seen, 3);
        chk("invalid_pending", bus.jobs_pending, 0);
        chk("invalid_no_start", n_starts, st0);

        // Queue full with the core held busy.
        st0 = n_starts;
        hold_busy = 1'b1;
        for (int i = 0; i < 4; i++) push_job(16'(10 + i), 16'(20 + i), 16'(16'h0100 + i));
        chk("full_ready_low", bus.job_ready, 0);
        chk("full_pending", bus.jobs_pending, 4);
        fork
            push_job(16'd99, 16'd98, 16'h0180);
            begin
                repeat (6) @(negedge clk_50);
                chk("full_held_pending", bus.jobs_pending, 4);
                chk("full_no_start_busy", n_starts, st0);
                hold_busy = 1'b0;
            end
        join
        wait_idle("full_idle");
        chk("full_all_started", n_starts, st0 + 5);
        chk("full_pending_end", bus.jobs_pending, 0);

        // Randomized traffic.
        for (int i = 0; i < 20; i++) begin
            logic [15:0] w, h, s;
            w = 16'($urandom_range(1, 65535));
            h = 16'($urandom_range(1, 65535));
            s = 16'($urandom_range(1, 65535));
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0: w = 16'd0;
                    1: h = 16'd0;
                    default: s = 16'd0;
                endcase
            end
            repeat ($urandom_range(0, 4)) @(negedge clk_50);
            push_job(w, h, s);
        end
        wait_idle("random_idle");

        // Done exactly at and just below the watchdog limit.
        lat_q.push_back(TIMEOUT - 1);
        lat_q.push_back(TIMEOUT);
        push_job(16'd320, 16'd240, 16'h0200);
        push_job(16'd640, 16'd480, 16'h0080);
        wait_idle("limit_idle");
        chk("limit_no_timeout", bus.stat_timeout, 0);

        // Watchdog: the core hangs and stays busy.
        s0 = n_stats;
        st0 = n_starts;
        lat_q.push_back(0);
        push_job(16'd11, 16'd12, 16'h0013);
        wait_stats("wd_stat_seen", s0 + 1);
        chk("wd_sticky", bus.stat_timeout, 1);
        push_job(16'd21, 16'd22, 16'h0023);
        repeat (30) @(negedge clk_50);
        chk("wd_waits_for_busy", n_starts, st0 + 1);
        chk("wd_pending", bus.jobs_pending, 1);
        release_hang = 1'b1;
        wait_idle("wd_idle");
        release_hang = 1'b0;
        chk("wd_next_started", n_starts, st0 + 2);
        chk("wd_still_sticky", bus.stat_timeout, 1);

        // Abort with one job running and two queued.
        s0 = n_stats;
        st0 = n_starts;
        lat_q.push_back(40);
        push_job(16'd1, 16'd2, 16'h0003);
        push_job(16'd4, 16'd5, 16'h0006);
        push_job(16'd7, 16'd8, 16'h0009);
        wait_starts("abort_first_start", st0 + 1);
        chk("abort_pending_before", bus.jobs_pending, 2);
        do_abort();
        chk("abort_pending_after", bus.jobs_pending, 0);
        wait_idle("abort_idle");
        chk("abort_one_start", n_starts, st0 + 1);
        chk("abort_running_done", n_stats, s0 + 1);
        chk("abort_idle_after", bus.idle, 1);

        // Asynchronous reset while a job runs.
        st0 = n_starts;
        lat_q.push_back(80);
        push_job(16'd30, 16'd31, 16'h0032);
        wait_starts("rst_run_start", st0 + 1);
        push_job(16'd40, 16'd41, 16'h0042);
        repeat (10) @(negedge clk_50);
        rst_n = 1'b0;
        #1;
        chk("rstrun_idle", bus.idle, 1);
        chk("rstrun_ready", bus.job_ready, 1);
        chk("rstrun_pending", bus.jobs_pending, 0);
        chk("rstrun_flags", {bus.core_start, bus.stat_valid, bus.stat_timeout, bus.job_reject},
            4'b0000);
        chk("rstrun_core_cfg", {bus.core_in_w, bus.core_in_h, bus.core_scale_q88}, 48'd0);
        chk("rstrun_stat_cycles", bus.stat_cycles, 0);
        cfg_q.delete();
        stat_q.delete();
        lat_q.delete();
        sticky = 1'b0;
        repeat (3) @(negedge clk_50);
        rst_n = 1'b1;
        repeat (40) @(negedge clk_50);
        chk("rstrun_no_start", n_starts, st0 + 1);
        chk("rstrun_idle_after", bus.idle, 1);

        chk("reject_total", n_rej_seen, exp_rej);
        chk("cfg_queue_drained", cfg_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
